vector_accumulator: RTL and testbench
=====================================

# vector_accumulator

Multi-lane, handshaked successor to the single-lane accumulator. It sums a programmable number of signed input vectors, with CHANNELS independent lanes and per-lane overflow detection. The block sits between the lane-parallel datapath and the result collector, which receives one packed result vector per accumulation run. Input is valid/ready; output is held until the collector accepts it.

## Interface
- DATA_WIDTH, 4, width of each signed input lane
- CHANNELS, 4, number of independent lanes
- GUARD_BITS, 3, extra accumulator bits; ACC_W = DATA_WIDTH+GUARD_BITS
- COUNT_WIDTH, 8, width of the term counter
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse that begins a run; honoured only in IDLE
- num_terms  in  COUNT_WIDTH  number of input beats to sum; latched on start
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts a beat
- in_data  in  CHANNELS*DATA_WIDTH  packed signed lanes; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH]
- out_valid  out  1  results available
- out_ready  in  1  collector accepts the results
- out_data  out  CHANNELS*ACC_W  packed signed sums, packed the same way as in_data
- overflow  out  CHANNELS  sticky per-lane overflow flag, valid while out_valid
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ACCUM, HOLD.
- In IDLE:
  - in_ready=0, out_valid=0.
  - On start: latch num_terms, clear all sums, overflow flags and the counter.
  - If num_terms==0, go to HOLD; otherwise go to ACCUM.
- In ACCUM:
  - in_ready=1.
  - A beat is accepted when in_valid&&in_ready. On each accepted beat, every lane sign-extends its input to ACC_W and adds it to that lane's sum, and the counter increments.
  - The beat that brings the counter to the latched num_terms moves the FSM to HOLD.
  - in_valid low: no change.
- In HOLD:
  - out_valid=1; out_data and overflow are stable.
  - On out_valid&&out_ready, go to IDLE. The sums keep their values until the next start.
- start outside IDLE is ignored, including start in HOLD in the same cycle as out_ready.
- Arithmetic, per lane:
  - Two's complement, ACC_W bits, lanes fully independent.
  - Overflow is detected when the exact sum of the addition is not representable in ACC_W bits. The overflow flag, once set, stays set until the next start.
- Reset (rst=1), including mid-run:
  - State returns to IDLE; any partial run is discarded.
  - Sums, counter, overflow flags and the latched num_terms clear to 0.
  - Outputs: in_ready=0, out_valid=0, out_data=0, overflow=0, busy=0.

## Timing
- A start sampled at edge N puts the FSM in ACCUM at N+1, so in_ready=1 from cycle N+1.
- The last beat accepted at edge M gives out_valid=1 from cycle M+1, with the final sums.
- Throughput: one beat per cycle with no bubbles. A full run takes num_terms+2 cycles minimum: start, num_terms beats, one HOLD cycle with out_ready=1.
- A num_terms==0 start at edge N gives out_valid=1 at N+1, with all-zero results.
- out_data and overflow never change while out_valid=1.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Configuration
- ACC_SATURATE_EN defined: on overflow, each lane clamps to +2^(ACC_W-1)-1 or -2^(ACC_W-1). The saturated value is used as the base for later additions. The overflow flag still sets.
- ACC_SATURATE_EN undefined: lanes wrap modulo 2^ACC_W, and the overflow flag sets.

## Structure
- Package vector_accumulator_pkg holds:
  - the state enum (IDLE, ACCUM, HOLD);
  - the localparam/function for ACC_W;
  - the saturation min/max helpers.
- Sub-module accumulator_lane holds one lane's sum register, sign extension, add, overflow detection and optional clamp. It is generated CHANNELS times.
- The top level holds the FSM, counter, handshake, packing and unpacking.

## Test plan
All scenarios use the default parameters: ACC_W=7, range -64..63.
- Reset: drive rst for 2 cycles with random inputs → all outputs 0, busy=0, in_ready=0.
- Basic run: num_terms=3; lane0 beats 1,2,3; lane1 beats -1,-2,-3; lanes 2 and 3 at 0 → out_valid the cycle after the 3rd accept, with lane0=6, lane1=-6, lane2=lane3=0, overflow=0.
- Backpressure: num_terms=4 with in_valid toggling 1,0,1,0…, then out_ready held low for 5 cycles → same sums as with gapless input; out_data stable across the stall; IDLE one cycle after out_ready rises.
- Zero terms: num_terms=0 → out_valid at N+1, out_data=0, no input beats accepted.
- Overflow: num_terms=20, lane0=7 on every beat, lane1=-8 on every beat →
  - ACC_SATURATE_EN undefined: lane0=12, lane1=-32, overflow=2'b11.
  - ACC_SATURATE_EN defined: lane0=63, lane1=-64, overflow=2'b11.
- Abort: assert rst after 2 of 5 beats → IDLE with zeros. A new start with num_terms=2 and lane0 beats 5,5 then gives lane0=10. A start pulsed during ACCUM is ignored.

Source files
------------

// File: rtl/vector_accumulator_pkg.sv
// rtl/vector_accumulator_pkg.sv - shared types and arithmetic helpers for vector_accumulator
package vector_accumulator_pkg;

  // Run-control states for the accumulation FSM
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Accumulator width: input width plus headroom bits
  function automatic int acc_width(input int data_width, input int guard_bits);
    return data_width + guard_bits;
  endfunction

  // Largest positive value representable in w-bit two's complement
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Most negative value representable in w-bit two's complement
  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/accumulator_lane.sv
// rtl/accumulator_lane.sv - one signed accumulator lane with overflow detect; ACC_SATURATE_EN selects clamping
module accumulator_lane
  import vector_accumulator_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ACC_W      = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  add_en,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [ACC_W-1:0]      sum,
  output logic                  overflow
);

  // One extra bit holds the exact sum of an ACC_W-bit value and a narrower one
  logic signed [ACC_W:0]   sum_x;
  logic signed [ACC_W:0]   in_x;
  logic signed [ACC_W:0]   exact;
  logic                    add_ovf;
  logic        [ACC_W-1:0] sum_nxt;

  assign sum_x   = {sum[ACC_W-1], sum};
  assign in_x    = {{(ACC_W + 1 - DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};
  assign exact   = sum_x + in_x;
  // Result not representable when the top two bits of the exact sum disagree
  assign add_ovf = exact[ACC_W] ^ exact[ACC_W-1];

`ifdef ACC_SATURATE_EN
  localparam logic [ACC_W-1:0] LANE_MAX = ACC_W'(sat_max(ACC_W));
  localparam logic [ACC_W-1:0] LANE_MIN = ACC_W'(sat_min(ACC_W));

  // Clamp toward the true sign of the exact sum; clamped value is the next base
  always_comb begin
    sum_nxt = exact[ACC_W-1:0];
    if (add_ovf) begin
      sum_nxt = exact[ACC_W] ? LANE_MIN : LANE_MAX;
    end
  end
`else
  // Plain modulo-2^ACC_W wrap
  always_comb begin
    sum_nxt = exact[ACC_W-1:0];
  end
`endif

  // Sum and sticky overflow: cleared by reset or run start, updated per accepted beat
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sum      <= '0;
      overflow <= 1'b0;
    end else if (add_en) begin
      sum      <= sum_nxt;
      overflow <= overflow | add_ovf;
    end
  end

endmodule

// File: rtl/vector_accumulator.sv
// rtl/vector_accumulator.sv - multi-lane handshaked vector accumulator; ACC_SATURATE_EN enables lane saturation
module vector_accumulator
  import vector_accumulator_pkg::*;
#(
  parameter int DATA_WIDTH  = 4,
  parameter int CHANNELS    = 4,
  parameter int GUARD_BITS  = 3,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start,
  input  logic [COUNT_WIDTH-1:0]                        num_terms,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0]                in_data,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [CHANNELS*(DATA_WIDTH+GUARD_BITS)-1:0]   out_data,
  output logic [CHANNELS-1:0]                           overflow,
  output logic                                          busy
);

  localparam int ACC_W = acc_width(DATA_WIDTH, GUARD_BITS);

  state_t                 state;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] terms_q;
  logic [COUNT_WIDTH-1:0] count_nxt;
  logic                   lane_clear;
  logic                   beat;

  // A start is only honoured in IDLE; beats only count in ACCUM with the handshake
  assign lane_clear = (state == IDLE) && start;
  assign beat       = (state == ACCUM) && in_valid && in_ready;
  assign count_nxt  = count_q + COUNT_WIDTH'(1);

  // Run-control FSM with registered handshake and busy outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count_q   <= '0;
      terms_q   <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            terms_q <= num_terms;
            count_q <= '0;
            busy    <= 1'b1;
            if (num_terms == '0) begin
              state     <= HOLD;
              out_valid <= 1'b1;
            end else begin
              state    <= ACCUM;
              in_ready <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (beat) begin
            count_q <= count_nxt;
            if (count_nxt == terms_q) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // One independent lane per channel; sums drive out_data directly and only move in ACCUM
  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    accumulator_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_W      (ACC_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .clear    (lane_clear),
      .add_en   (beat),
      .in_data  (in_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .sum      (out_data[i*ACC_W +: ACC_W]),
      .overflow (overflow[i])
    );
  end

endmodule

// File: tb/tb_vector_accumulator.sv
// tb/tb_vector_accumulator.sv - table-driven self-checking bench for vector_accumulator
module tb_vector_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  num_terms;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [27:0] out_data;
  logic [3:0]  overflow;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vector_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_terms (num_terms),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .overflow  (overflow),
    .busy      (busy)
  );

  typedef struct {
    int        n;
    int        b0, s0, b1, s1, c2, c3;
    bit        gap;
    int        stall;
    int        e0, e1, e2, e3;
    logic [3:0] eovf;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [15:0] pack(input int a, input int b, input int c, input int d);
    logic [3:0] la, lb, lc, ld;
    la = 4'(a); lb = 4'(b); lc = 4'(c); ld = 4'(d);
    return {ld, lc, lb, la};
  endfunction

  function automatic int lane(input logic [27:0] d, input int i);
    logic signed [6:0] v;
    v = d[i*7 +: 7];
    return int'(v);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_result(input string tag, input vec_t v);
    check({tag, " lane0"}, lane(out_data, 0), v.e0);
    check({tag, " lane1"}, lane(out_data, 1), v.e1);
    check({tag, " lane2"}, lane(out_data, 2), v.e2);
    check({tag, " lane3"}, lane(out_data, 3), v.e3);
    check({tag, " overflow"}, int'(overflow), int'(v.eovf));
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int k;
    int cyc;
    bit acc;
    @(negedge clk);
    start = 1'b1;
    num_terms = 8'(v.n);
    @(negedge clk);
    start = 1'b0;
    num_terms = 8'd0;
    check({tag, " in_ready after start"}, int'(in_ready), 1);
    check({tag, " busy after start"}, int'(busy), 1);
    k = 0;
    cyc = 0;
    while (k < v.n && cyc < 200) begin
      in_valid = !(v.gap && cyc[0]);
      in_data = pack(v.b0 + k * v.s0, v.b1 + k * v.s1, v.c2, v.c3);
      acc = in_valid && in_ready;
      @(negedge clk);
      if (acc) k++;
      cyc++;
    end
    in_valid = 1'b0;
    in_data = '0;
    check({tag, " beats accepted"}, k, v.n);
    check({tag, " out_valid"}, int'(out_valid), 1);
    check({tag, " in_ready in hold"}, int'(in_ready), 0);
    check_result(tag, v);
    for (int s = 0; s < v.stall; s++) begin
      @(negedge clk);
      check({tag, " out_valid stall"}, int'(out_valid), 1);
      check_result({tag, " stall"}, v);
    end
    // start alongside out_ready in HOLD must be ignored
    out_ready = 1'b1;
    start = 1'b1;
    num_terms = 8'd3;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    num_terms = 8'd0;
    check({tag, " out_valid after accept"}, int'(out_valid), 0);
    check({tag, " busy after accept"}, int'(busy), 0);
    check({tag, " in_ready after accept"}, int'(in_ready), 0);
    check({tag, " lane0 retained in idle"}, lane(out_data, 0), v.e0);
  endtask

  initial begin
    vec_t ab;
    vecs[0] = '{n:3,  b0:1,  s0:1, b1:-1, s1:-1, c2:0,  c3:0,  gap:0, stall:0, e0:6,  e1:-6, e2:0,   e3:0,  eovf:4'b0000};
    vecs[1] = '{n:4,  b0:-2, s0:1, b1:3,  s1:1,  c2:-1, c3:7,  gap:1, stall:5, e0:-2, e1:18, e2:-4,  e3:28, eovf:4'b0000};
    vecs[2] = '{n:5,  b0:0,  s0:0, b1:0,  s1:0,  c2:-3, c3:5,  gap:0, stall:0, e0:0,  e1:0,  e2:-15, e3:25, eovf:4'b0000};
    vecs[3] = '{n:8,  b0:7,  s0:0, b1:-8, s1:0,  c2:0,  c3:0,  gap:0, stall:0, e0:56, e1:-64, e2:0,  e3:0,  eovf:4'b0000};
`ifdef ACC_SATURATE_EN
    vecs[4] = '{n:10, b0:7,  s0:0, b1:-8, s1:0,  c2:0,  c3:7,  gap:0, stall:0, e0:63, e1:-64, e2:0,  e3:63, eovf:4'b1011};
    vecs[5] = '{n:20, b0:7,  s0:0, b1:-8, s1:0,  c2:0,  c3:0,  gap:0, stall:0, e0:63, e1:-64, e2:0,  e3:0,  eovf:4'b0011};
`else
    vecs[4] = '{n:10, b0:7,  s0:0, b1:-8, s1:0,  c2:0,  c3:7,  gap:0, stall:0, e0:-58, e1:48, e2:0,  e3:-58, eovf:4'b1011};
    vecs[5] = '{n:20, b0:7,  s0:0, b1:-8, s1:0,  c2:0,  c3:0,  gap:0, stall:0, e0:12, e1:-32, e2:0,  e3:0,  eovf:4'b0011};
`endif
    vecs[6] = '{n:1,  b0:-8, s0:0, b1:7,  s1:0,  c2:1,  c3:-1, gap:0, stall:0, e0:-8, e1:7,  e2:1,   e3:-1, eovf:4'b0000};

    // Reset with random inputs
    rst = 1'b1;
    start = 1'($urandom);
    num_terms = 8'($urandom);
    in_valid = 1'($urandom);
    in_data = 16'($urandom);
    out_ready = 1'($urandom);
    @(negedge clk);
    @(negedge clk);
    check("reset out_valid", int'(out_valid), 0);
    check("reset in_ready", int'(in_ready), 0);
    check("reset busy", int'(busy), 0);
    check("reset out_data", int'(out_data), 0);
    check("reset overflow", int'(overflow), 0);
    rst = 1'b0;
    start = 1'b0;
    num_terms = '0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    @(negedge clk);
    check("idle busy", int'(busy), 0);

    for (int i = 0; i < 7; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Zero-term run: results at N+1, no beats taken
    @(negedge clk);
    start = 1'b1;
    num_terms = 8'd0;
    in_valid = 1'b1;
    in_data = pack(1, 1, 1, 1);
    @(negedge clk);
    start = 1'b0;
    check("zero out_valid", int'(out_valid), 1);
    check("zero in_ready", int'(in_ready), 0);
    check("zero out_data", int'(out_data), 0);
    check("zero overflow", int'(overflow), 0);
    @(negedge clk);
    check("zero out_data held", int'(out_data), 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    check("zero out_valid after accept", int'(out_valid), 0);
    check("zero busy after accept", int'(busy), 0);

    // Abort: reset after two of five beats, with a start pulsed in ACCUM
    @(negedge clk);
    start = 1'b1;
    num_terms = 8'd5;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_data = pack(5, 0, 0, 0);
    @(negedge clk);
    start = 1'b1;
    num_terms = 8'd1;
    @(negedge clk);
    start = 1'b0;
    num_terms = 8'd0;
    in_valid = 1'b0;
    in_data = '0;
    check("abort start ignored in_ready", int'(in_ready), 1);
    check("abort start ignored out_valid", int'(out_valid), 0);
    check("abort partial lane0", lane(out_data, 0), 10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", int'(busy), 0);
    check("abort in_ready", int'(in_ready), 0);
    check("abort out_valid", int'(out_valid), 0);
    check("abort out_data", int'(out_data), 0);
    ab = '{n:2, b0:5, s0:0, b1:0, s1:0, c2:0, c3:0, gap:0, stall:0, e0:10, e1:0, e2:0, e3:0, eovf:4'b0000};
    run_vec("after abort", ab);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
